// File: rtl/loading_b_if.sv
// Symbol-stream bundle between the V-stage and the B-insertion stage.
// master drives the strobe and input symbol; slave returns the coded output stream.
// No flow control beyond the en strobe: the slave accepts every strobed symbol.
interface loading_b_if;
  logic       en;
  logic [1:0] v_data;
  logic [1:0] b_data;
  logic       out_valid;

  modport master (output en, output v_data, input b_data, input out_valid);
  modport slave  (input en, input v_data, output b_data, output out_valid);
endinterface

// File: rtl/loading_b.sv
// Balance-pulse (B) insertion stage: 4-deep symbol delay line with B substitution.
// Latency: a symbol accepted on accept edge k is on b_data after accept edge k+4.
// No backpressure: en=0 freezes all state and drops out_valid; every en=1 edge is accepted.
module loading_b #(
  parameter logic [1:0] ZERO = 2'b00,
  parameter logic [1:0] ONE  = 2'b01,
  parameter logic [1:0] V    = 2'b10,
  parameter logic [1:0] B    = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  loading_b_if.slave  bus
);

  logic [1:0] s0_q, s1_q, s2_q, s3_q, b_q;
  logic [1:0] s0_d, s1_d, s2_d, s3_d, b_d;
  logic       parity_q, parity_d;
  logic       vld_q, vld_d;
  logic [2:0] fill_q, fill_d;

  logic [1:0] sym_in;
  logic       is_v;
  logic       is_one;
  logic       ins_b;

  // Decode the upstream symbol; the unused code 2'b11 is treated as a plain ZERO.
  always_comb begin
    sym_in = ZERO;
    is_v   = 1'b0;
    is_one = 1'b0;
    case (bus.v_data)
      2'b01: begin
        sym_in = ONE;
        is_one = 1'b1;
      end
      2'b10: begin
        sym_in = V;
        is_v   = 1'b1;
      end
      default: sym_in = ZERO;
    endcase
    // An even-parity V needs its balancing pulse three symbols earlier, which sits in s2.
    ins_b = is_v && !parity_q && (s2_q == ZERO);
  end

  // Next state: shift on accept, otherwise hold everything and drop out_valid.
  always_comb begin
    s0_d     = s0_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    b_d      = b_q;
    parity_d = parity_q;
    fill_d   = fill_q;
    vld_d    = 1'b0;
    if (bus.en) begin
      s0_d  = sym_in;
      s1_d  = s0_q;
      s2_d  = s1_q;
      s3_d  = ins_b ? B : s2_q;
      b_d   = s3_q;
      vld_d = (fill_q == 3'd4);
      if (fill_q != 3'd4) begin
        fill_d = fill_q + 3'd1;
      end
      if (is_v) begin
        parity_d = 1'b0;
      end else if (is_one) begin
        parity_d = ~parity_q;
      end
    end
  end

  // State registers; reset empties the delay line and restarts the fill count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q     <= ZERO;
      s1_q     <= ZERO;
      s2_q     <= ZERO;
      s3_q     <= ZERO;
      b_q      <= ZERO;
      parity_q <= 1'b0;
      fill_q   <= 3'd0;
      vld_q    <= 1'b0;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      b_q      <= b_d;
      parity_q <= parity_d;
      fill_q   <= fill_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.b_data    = b_q;
  assign bus.out_valid = vld_q;

endmodule

// File: doc/loading_b.md
LOADING_B -- requirements
Module: loading_B

Interface
REQ-001 Parameter ZERO, default 2'b00, symbol code for a space (0).
REQ-002 Parameter ONE, default 2'b01, symbol code for a mark (1).
REQ-003 Parameter V, default 2'b10, symbol code for a violation pulse.
REQ-004 Parameter B, default 2'b11, symbol code for a balance pulse.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  symbol strobe; one input symbol is accepted per rising clk edge while en=1.
REQ-008 v_data  input  2  upstream V-stage symbol: bit1=V flag, bit0=original data bit.
REQ-009 b_data  output  2  registered symbol stream with B inserted, coded ZERO/ONE/V/B.
REQ-010 out_valid  output  1  registered; 1 for exactly the cycle after each accept edge that emits a symbol.

Function
REQ-011 The block SHALL hold a 4-deep symbol delay line s0..s3 (s0 newest), shifted only on edges with en=1: s0<=v_data, s1<=s0, s2<=s1, s3<=s2, b_data<=s3.
REQ-012 Latency SHALL be exactly 4 accepts: the symbol accepted on accept edge k appears on b_data after accept edge k+4, with B substitution applied.
REQ-013 With en=0: s0..s3, b_data, parity and fill counter SHALL hold; out_valid SHALL be 0 after that edge.
REQ-014 A 3-bit fill counter SHALL count accepts from reset and saturate at 4; out_valid SHALL be set on an accept edge only if fill was 4 before that edge, else 0.
REQ-015 A 1-bit parity register SHALL track the number of ONE symbols accepted since the last V (or since reset), toggling on each accepted ONE.
REQ-016 On an accept edge with v_data=V and parity=0 (even) and s2=ZERO, s3 SHALL be loaded with B instead of s2; otherwise s3<=s2 unchanged.
REQ-017 On an accept edge with v_data=V, parity SHALL clear to 0 regardless of whether B was inserted.
REQ-018 If v_data=V arrives with s2 not ZERO (malformed upstream), no B SHALL be inserted, and parity still clears.
REQ-019 An input of 2'b11 SHALL be stored as ZERO and SHALL NOT affect parity.
REQ-020 ZERO, ONE and V symbols SHALL pass through unchanged except for the single B substitution of REQ-016.
REQ-021 b_data SHALL never be driven to high impedance; it always holds a defined 2-bit code.
REQ-022 Simultaneous V accept and output emission SHALL both occur on the same edge: b_data takes the old s3 while s3 takes B or s2.

Reset
REQ-023 rst=0 SHALL immediately clear s0..s3 to ZERO, b_data to ZERO, out_valid to 0, parity to 0 and fill to 0, independent of clk and en.
REQ-024 Reset asserted mid-stream SHALL discard all buffered symbols; after release, behaviour SHALL be identical to power-up, and the first out_valid follows the 5th accept.

Verification
REQ-025 Reset, en=1, v_data 01,00,00,00,10 then 00 x4 -> emitted symbols 01,00,00,00,10 (odd parity, no B); out_valid first high after 5th edge.
REQ-026 Reset, v_data 00,00,00,10 then 00 x4 -> emitted 11,00,00,10 (even parity at first V, B inserted).
REQ-027 v_data 01,01,00,00,00,10 then flush zeros -> emitted 01,01,11,00,00,10.
REQ-028 v_data 00,00,00,10,00,00,00,10 -> emitted 11,00,00,10,11,00,00,10 (parity cleared after each V).
REQ-029 Same stimulus as REQ-027 with en=0 for 2 cycles between each symbol -> identical emitted sequence; b_data held and out_valid=0 during gaps.
REQ-030 Pulse rst=0 for one cycle after 3 accepts of REQ-027 stimulus -> b_data=00, out_valid=0 at once; restarting with REQ-026 stimulus reproduces REQ-026 output.
